// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file's single write port
// between NUM_REQ writeback requesters. The winning write is registered so
// the register file sees clean enable/address/data, and the same registered
// write is exposed as a forwarding tap. A saturating counter tracks committed
// non-r0 writes.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    output logic                      reg_write_en,
    output logic [ADDR_W-1:0]         reg_write_dest,
    output logic [DATA_W-1:0]         reg_write_data,
    output logic                      fwd_valid,
    output logic [ADDR_W-1:0]         fwd_dest,
    output logic [DATA_W-1:0]         fwd_data,
    output logic [2:0]                grant_id,
    output logic [CNT_W-1:0]          wb_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Unpacked views of the flattened requester buses
    logic [ADDR_W-1:0] dest_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign dest_arr[gi] = req_dest[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic              write_en_reg;
    logic [ADDR_W-1:0] write_dest_reg;
    logic [DATA_W-1:0] write_data_reg;
    logic [2:0]        grant_id_reg;
    logic [CNT_W-1:0]  wb_count_reg;

    logic [NUM_REQ-1:0] grant_vec;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [ADDR_W-1:0]  win_dest;
    logic [DATA_W-1:0]  win_data;
    logic [PTR_W-1:0]   rr_ptr_next;
    logic               transfer;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    // Each distance k maps to requester j when rr_ptr+k equals j or j+NUM_REQ,
    // which avoids variable-width indexing into the requester arrays.
    always_comb begin
        grant_vec   = '0;
        win_found   = 1'b0;
        win_idx     = '0;
        win_dest    = '0;
        win_data    = '0;
        rr_ptr_next = rr_ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && req_valid[j] &&
                    ((int'(rr_ptr_reg) + k == j) || (int'(rr_ptr_reg) + k == j + NUM_REQ))) begin
                    win_found    = 1'b1;
                    grant_vec[j] = 1'b1;
                    win_idx      = 3'(j);
                    win_dest     = dest_arr[j];
                    win_data     = data_arr[j];
                    rr_ptr_next  = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
                end
            end
        end
    end

    // Grants are suppressed while held or while reset is asserted
    assign req_ready = (rst_n && !wb_hold) ? grant_vec : '0;
    assign transfer  = |req_ready;

    // Pointer, registered write port, grant id and committed-write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg     <= '0;
            write_en_reg   <= 1'b0;
            write_dest_reg <= '0;
            write_data_reg <= '0;
            grant_id_reg   <= '0;
            wb_count_reg   <= '0;
        end else begin
            // r0 writes are accepted but never enable the port
            write_en_reg <= transfer && (win_dest != '0);
            if (transfer) begin
                rr_ptr_reg     <= rr_ptr_next;
                write_dest_reg <= win_dest;
                write_data_reg <= win_data;
                grant_id_reg   <= win_idx;
            end
            // Count a write in the cycle it is committed; stick at all-ones
            if (write_en_reg && (wb_count_reg != '1)) begin
                wb_count_reg <= wb_count_reg + 1'b1;
            end
        end
    end

    assign reg_write_en   = write_en_reg;
    assign reg_write_dest = write_dest_reg;
    assign reg_write_data = write_data_reg;
    assign fwd_valid      = write_en_reg;
    assign fwd_dest       = write_dest_reg;
    assign fwd_data       = write_data_reg;
    assign grant_id       = grant_id_reg;
    assign wb_count       = wb_count_reg;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ writeback requesters, e.g. the ALU result and the load-return path.
- Uses fair round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write so the register file sees clean, glitch-free write-enable, destination and data.
- Exposes that in-flight write as a forwarding tap and keeps a saturating count of committed writes.
- Sits between the execute/load stages and the register file's write port.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..8).
- ADDR_W, 4, register address width (16 registers).
- DATA_W, 8, register data width.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, NUM_REQ: requester i has a write pending.
- req_dest, input, NUM_REQ*ADDR_W: destination of requester i, in slice [i*ADDR_W +: ADDR_W].
- req_data, input, NUM_REQ*DATA_W: data of requester i, in slice [i*DATA_W +: DATA_W].
- req_ready, output, NUM_REQ: one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- wb_hold, input, 1: when 1, no grants are issued this cycle.
- reg_write_en, output, 1: write enable to the register file.
- reg_write_dest, output, ADDR_W: write address to the register file.
- reg_write_data, output, DATA_W: write data to the register file.
- fwd_valid, output, 1: equals reg_write_en; a write to fwd_dest is in flight.
- fwd_dest, output, ADDR_W: equals reg_write_dest.
- fwd_data, output, DATA_W: equals reg_write_data.
- grant_id, output, 3: index of the last accepted requester.
- wb_count, output, CNT_W: number of committed non-r0 writes, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rr_ptr=0.
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0.
  - grant_id=0, wb_count=0.
  - req_ready is 0 for as long as rst_n=0.
  - An accepted but not yet driven write is discarded; the requester has already seen its handshake, so the loss is accepted by design.
- Arbitration (combinational, in the same cycle):
  - Search requesters starting at rr_ptr, ascending with wrap-around at NUM_REQ-1 back to 0.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0.
  - If wb_hold=1 or no requester is valid, req_ready=0.
  - req_ready never depends on req_ready itself, so there are no combinational loops. It depends only on req_valid, rr_ptr, wb_hold and rst_n.
- Pointer update: on a transfer from requester i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Requester rule: once req_valid[i] is asserted, req_valid, req_dest and req_data must stay stable until the transfer. The bench flags any violation.
- Write register, on every posedge:
  - reg_write_en <= transfer & (dest != 0).
  - reg_write_dest and reg_write_data are loaded on a transfer and hold otherwise.
  - Latency is 1 cycle: a transfer at edge N drives the port during cycle N..N+1, and the register file commits at edge N+1.
  - Each transfer drives reg_write_en for exactly one cycle.
- r0 writes: dest=0 is accepted (a normal handshake), but reg_write_en stays 0 and wb_count does not increment. r0 reads as zero, so the write is dropped.
- grant_id <= i on every transfer, including r0 transfers.
- wb_count increments by 1 on each cycle with reg_write_en=1. It saturates at 2^CNT_W-1 and never wraps.
- Throughput: at most one transfer per cycle. Back-to-back transfers from alternating requesters are allowed every cycle.
- Same destination from two requesters: they are serialised in grant order, and the later grant's data is the one that persists.
- wb_hold rising mid-stream:
  - Blocks the grant in the cycle it is high.
  - A write already registered still drives the port; hold does not cancel it.
  - rr_ptr is frozen while held.
- Single requester continuously valid: granted every cycle. rr_ptr keeps advancing past it, which is harmless.

Test Plan:
- Reset then idle: drive rst_n=0 mid-cycle. All outputs go to 0 immediately without a clock edge. After release with no valids: reg_write_en=0 and wb_count=0 for 10 cycles.
- Single write: req0 dest=5, data=8'hA7. req_ready[0]=1 in the same cycle. On the next cycle reg_write_en=1, dest=5, data=A7 and fwd_valid=1. One cycle later reg_write_en=0 and wb_count=1.
- Contention: both requesters valid continuously, req0 carrying (3,11), (4,22) and req1 carrying (7,33), (8,44), from rr_ptr=0. Port order must be r3, r7, r4, r8 on consecutive cycles, with grant_id sequence 0,1,0,1.
- r0 drop: req1 dest=0, data=FF. req_ready[1]=1 and grant_id=1, but reg_write_en stays 0 and wb_count is unchanged.
- Hold: both valid and wb_hold=1 for 3 cycles gives req_ready=0 and no writes. On release, the requester at rr_ptr is granted first.
- Reset mid-operation: a transfer at edge N followed by rst_n=0 before edge N+1 gives reg_write_en=0 at once and no write of that data. Then preload wb_count to 16'hFFFF-1 and do 3 writes: the count stops at FFFF.
